cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Responder side of the L1 miss interfaces. The I-cache and D-cache each raise a line request; this block serves them and returns the single-cycle resp that the caches forward as instr_mem_resp / data_mem_resp to the stall logic.
- Serializes both L1 miss streams onto one shared burst physical-memory port: 256-bit line, 4 beats x 64 bits.
- Sits between the L1 caches and pmem.

Parameters:
- LINE_W, 256, cache line width in bits.
- BEAT_W, 64, pmem data width per beat.
- (Fixed: BEATS = LINE_W/BEAT_W = 4.)

Ports:
- clk in 1: clock.
- rst in 1: asynchronous, active-high reset.
- i_read in 1: I-cache line read request.
- i_address in 32: I-cache line address.
- i_rdata out LINE_W: line returned to the I-cache.
- i_resp out 1: one-cycle completion pulse to the I-cache.
- d_read in 1: D-cache line fill request.
- d_write in 1: D-cache writeback request.
- d_address in 32: D-cache line address.
- d_wdata in LINE_W: writeback line.
- d_rdata out LINE_W: fill line returned to the D-cache.
- d_resp out 1: one-cycle completion pulse to the D-cache.
- pmem_read out 1: burst read to memory.
- pmem_write out 1: burst write to memory.
- pmem_address out 32: line-aligned burst address.
- pmem_wdata out BEAT_W: current write beat.
- pmem_rdata in BEAT_W: current read beat.
- pmem_resp in 1: beat accepted / beat data valid.

Behaviour:
- States: IDLE, I_RD, D_RD, D_WR, I_DONE, D_DONE. Registers: 2-bit beat counter, latched address, latched write line, two LINE_W read buffers.
- Reset (async) values:
  - State IDLE, beat = 0.
  - All outputs 0, including pmem_read/pmem_write, both rdata buffers and both resps.
  - Reset asserted mid-burst aborts the burst immediately; pmem strobes drop asynchronously.
- IDLE grant priority: d_write > d_read > i_read. A data miss stalls the whole pipeline, so it is served first.
- On grant:
  - Latch address with bits [4:0] forced to 0.
  - Latch d_wdata for D_WR.
  - beat <= 0. Enter the burst state the next cycle.
- d_read and d_write both high: protocol error. Serve the write; the read stays pending and is granted after D_DONE.
- Burst states:
  - pmem_read (I_RD, D_RD) or pmem_write (D_WR) is held high continuously, with pmem_address constant.
  - Each cycle with pmem_resp = 1 completes one beat.
  - Read beat k is stored into rdata[64k+63:64k].
  - For writes, pmem_wdata = wline[64*beat+63:64*beat] combinationally.
  - Beat increments on pmem_resp. On pmem_resp with beat == 3, go to the DONE state. Strobes drop in that same transition.
- I_DONE / D_DONE:
  - Drive i_resp / d_resp = 1 for exactly one cycle, then return to IDLE.
  - The rdata buffer stays stable from the resp cycle until the next burst to the same side begins.
- Requester rules:
  - Hold the request and address stable until it sees resp.
  - Drop or replace the request in the cycle after resp. IDLE never re-grants a stale request because DONE inserts one cycle.
- Minimum latency: grant cycle + 4 beat cycles + DONE = 6 cycles from request to resp, with pmem_resp always 1.
- Request deasserted mid-burst: ignored. The burst always completes and resp still pulses.
- Only one burst is outstanding; the other requester waits in IDLE arbitration.
- Beat counter wraps 3 -> 0 only via the DONE/grant path.

Optional Feature:
- Macro: CACHE_ARB_RR_EN.
- Defined:
  - IDLE arbitration between the I side and D side is round-robin. A 1-bit last_grant register, reset to I, selects which side wins when both request.
  - Within the D side, write still beats read.
- Undefined: fixed priority d_write > d_read > i_read as above. No last_grant register.

Decomposition:
- Shared rv32i_types package:
  - arb_state_t enum for the six states.
  - Constants LINE_W = 256, BEAT_W = 64, BEATS = 4, OFFSET_BITS = 5.
- One natural sub-module, line_beat_buffer:
  - Beat counter plus the LINE_W assemble/disassemble shift logic.
  - Instantiated once for the write path and used as the read assembler.
- FSM and arbitration stay in cache_mem_arbiter.

Test Plan:
- I-only read: i_read = 1, i_address = 0x0000_1234; pmem_resp always 1, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> pmem_address = 0x0000_1220, i_resp one pulse at cycle 6, i_rdata = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- D writeback: d_write = 1, d_address = 0x8000_0040, d_wdata = {0xDD.., 0xCC.., 0xBB.., 0xAA..} -> pmem_wdata sequence AA, BB, CC, DD; pmem_write high for 4 beat cycles; d_resp one pulse; i_resp stays 0.
- Simultaneous i_read and d_read in the same cycle, fixed priority -> D burst first, d_resp, one IDLE cycle, then I burst, i_resp. With CACHE_ARB_RR_EN after reset -> I is served first.
- Wait-stated memory: pmem_resp asserted only every 3rd cycle -> exactly 4 beats captured, address and strobe held stable throughout, no extra beats, resp follows the 4th beat by 1 cycle.
- Reset asserted during beat 2 of D_RD -> pmem_read = 0 immediately, d_resp never pulses. After release with d_read still high -> a fresh 4-beat burst from beat 0.
- d_read and d_write both high -> write burst first, then the read burst to the same address, then two d_resp pulses total.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types and line/beat geometry for the L1-miss to pmem arbiter.
package rv32i_types;

    localparam int LINE_W      = 256;
    localparam int BEAT_W      = 64;
    localparam int BEATS       = LINE_W / BEAT_W;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_RD   = 3'd1,
        ST_D_RD   = 3'd2,
        ST_D_WR   = 3'd3,
        ST_I_DONE = 3'd4,
        ST_D_DONE = 3'd5
    } arb_state_t;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Burst physical-memory port: the arbiter is the master, the memory the slave.
interface cache_mem_arbiter_if #(
    parameter int BEAT_W = 64
);
    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [BEAT_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/line_beat_buffer.sv
// Beat counter plus one line register: disassembles a writeback line into
// beats and assembles read beats into a line.
module line_beat_buffer
    import rv32i_types::*;
#(
    parameter int LINE_W = rv32i_types::LINE_W,
    parameter int BEAT_W = rv32i_types::BEAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load_line,
    input  logic              capture,
    input  logic              beat_en,
    input  logic [LINE_W-1:0] line_in,
    input  logic [BEAT_W-1:0] beat_in,
    output logic              last,
    output logic [BEAT_W-1:0] beat_out,
    output logic [LINE_W-1:0] line_next
);

    logic [1:0]        beat;
    logic [LINE_W-1:0] line_q;

    assign last     = (beat == 2'(BEATS - 1));
    assign beat_out = line_q[beat*BEAT_W +: BEAT_W];

    // Line as it will look once the beat on the bus is merged in.
    always_comb begin
        line_next = line_q;
        line_next[beat*BEAT_W +: BEAT_W] = beat_in;
    end

    // The counter parks on the last beat; only a new grant brings it back to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat   <= 2'd0;
            line_q <= '0;
        end else if (start) begin
            beat   <= 2'd0;
            line_q <= load_line ? line_in : '0;
        end else if (beat_en) begin
            if (capture) line_q <= line_next;
            if (!last)   beat   <= beat + 2'd1;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Serves I-cache and D-cache line misses over one 4-beat burst pmem port.
// Optional CACHE_ARB_RR_EN: round-robin between the I and D sides in IDLE.
module cache_mem_arbiter
    import rv32i_types::*;
#(
    parameter int LINE_W = rv32i_types::LINE_W,
    parameter int BEAT_W = rv32i_types::BEAT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_read,
    input  logic [31:0]                i_address,
    output logic [LINE_W-1:0]          i_rdata,
    output logic                       i_resp,
    input  logic                       d_read,
    input  logic                       d_write,
    input  logic [31:0]                d_address,
    input  logic [LINE_W-1:0]          d_wdata,
    output logic [LINE_W-1:0]          d_rdata,
    output logic                       d_resp,
    cache_mem_arbiter_if.master        pmem
);

    arb_state_t        state, state_nxt;
    logic [31:0]       addr_q;
    logic              grant_i, grant_d_rd, grant_d_wr, grant, start;
    logic              in_read, in_burst, beat_en, last;
    logic [BEAT_W-1:0] beat_out;
    logic [LINE_W-1:0] line_next;

`ifdef CACHE_ARB_RR_EN
    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    // Names the side that wins the next I/D tie; handed to the other side on every grant.
    logic last_grant;
    logic d_req;

    assign d_req = d_read | d_write;

    always_comb begin
        grant_i    = i_read & (~d_req | (last_grant == SIDE_I));
        grant_d_wr = d_write & ~grant_i;
        grant_d_rd = d_read & ~d_write & ~grant_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        last_grant <= SIDE_I;
        else if (start) last_grant <= grant_i ? SIDE_D : SIDE_I;
    end
`else
    // A data miss stalls the whole pipeline, so the D side always goes first.
    always_comb begin
        grant_d_wr = d_write;
        grant_d_rd = d_read & ~d_write;
        grant_i    = i_read & ~d_read & ~d_write;
    end
`endif

    assign grant    = grant_i | grant_d_rd | grant_d_wr;
    assign start    = (state == ST_IDLE) & grant;
    assign in_read  = (state == ST_I_RD) | (state == ST_D_RD);
    assign in_burst = in_read | (state == ST_D_WR);
    assign beat_en  = in_burst & pmem.pmem_resp;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant_d_wr)      state_nxt = ST_D_WR;
                else if (grant_d_rd) state_nxt = ST_D_RD;
                else if (grant_i)    state_nxt = ST_I_RD;
            end
            ST_I_RD: if (beat_en && last) state_nxt = ST_I_DONE;
            ST_D_RD: if (beat_en && last) state_nxt = ST_D_DONE;
            ST_D_WR: if (beat_en && last) state_nxt = ST_D_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read buffers take the full line on the last beat, so they are stable from resp onwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (start) addr_q <= line_align(grant_i ? i_address : d_address);
            if (beat_en && last) begin
                if (state == ST_I_RD) i_rdata <= line_next;
                if (state == ST_D_RD) d_rdata <= line_next;
            end
        end
    end

    line_beat_buffer #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W)
    ) u_line_buf (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .load_line (grant_d_wr),
        .capture   (in_read),
        .beat_en   (beat_en),
        .line_in   (d_wdata),
        .beat_in   (pmem.pmem_rdata),
        .last      (last),
        .beat_out  (beat_out),
        .line_next (line_next)
    );

    assign pmem.pmem_read    = in_read;
    assign pmem.pmem_write   = (state == ST_D_WR);
    assign pmem.pmem_address = addr_q;
    assign pmem.pmem_wdata   = beat_out;
    assign i_resp            = (state == ST_I_DONE);
    assign d_resp            = (state == ST_D_DONE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a small wait-stated pmem responder.
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read, d_read, d_write;
    logic [31:0]  i_address, d_address;
    logic [255:0] d_wdata, i_rdata, d_rdata;
    logic         i_resp, d_resp;

    always #5 clk = ~clk;

    cache_mem_arbiter_if pmem_if ();

    cache_mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_address (i_address),
        .i_rdata   (i_rdata),
        .i_resp    (i_resp),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_address (d_address),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_resp    (d_resp),
        .pmem      (pmem_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Responder state: beat table, wait-state period and per-burst bookkeeping.
    int          period     = 1;
    int          phase      = 0;
    int          rcnt       = 0;
    int          tot_beats  = 0;
    int          wr_cyc     = 0;
    int          stable_err = 0;
    int          i_resp_cnt = 0;
    int          d_resp_cnt = 0;
    logic [63:0] rtab [4];
    logic [63:0] wlog [4];
    logic [31:0] burst_addr = '0;

    initial begin
        pmem_if.pmem_resp  = 1'b0;
        pmem_if.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (i_resp) i_resp_cnt++;
            if (d_resp) d_resp_cnt++;
            if (pmem_if.pmem_read || pmem_if.pmem_write) begin
                if (phase == 0) burst_addr = pmem_if.pmem_address;
                else if (pmem_if.pmem_address !== burst_addr) stable_err++;
                if (pmem_if.pmem_write) wr_cyc++;
                phase++;
                if (phase % period == 0) begin
                    pmem_if.pmem_resp  = 1'b1;
                    pmem_if.pmem_rdata = rtab[rcnt % 4];
                    if (pmem_if.pmem_write) wlog[rcnt % 4] = pmem_if.pmem_wdata;
                    rcnt++;
                    tot_beats++;
                end else begin
                    pmem_if.pmem_resp = 1'b0;
                end
            end else begin
                pmem_if.pmem_resp = 1'b0;
                phase = 0;
                rcnt  = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic wait_resp(input bit side_d, input int budget, output int lat);
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (side_d ? d_resp : i_resp) begin
                lat = c;
                return;
            end
        end
    endtask

    task automatic clear_counts();
        tot_beats  = 0;
        wr_cyc     = 0;
        stable_err = 0;
        i_resp_cnt = 0;
        d_resp_cnt = 0;
    endtask

    task automatic set_tab(input logic [63:0] b0, b1, b2, b3);
        rtab[0] = b0; rtab[1] = b1; rtab[2] = b2; rtab[3] = b3;
    endtask

    function automatic logic [255:0] tab_line();
        return {rtab[3], rtab[2], rtab[1], rtab[0]};
    endfunction

    int lat;

    initial begin
        rst = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_address = '0; d_address = '0; d_wdata = '0;
        set_tab('0, '0, '0, '0);
        repeat (3) @(negedge clk);
        check("rst_pmem_read", pmem_if.pmem_read, 1'b0);
        check("rst_pmem_write", pmem_if.pmem_write, 1'b0);
        check("rst_pmem_addr", pmem_if.pmem_address, 32'h0);
        check("rst_pmem_wdata", pmem_if.pmem_wdata, 64'h0);
        check("rst_resps", {i_resp, d_resp}, 2'b00);
        check("rst_i_rdata", i_rdata, 256'h0);
        check("rst_d_rdata", d_rdata, 256'h0);
        rst = 1'b0;
        @(negedge clk);

        // I-only read
        set_tab(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        clear_counts();
        i_read = 1'b1; i_address = 32'h0000_1234;
        wait_resp(1'b0, 20, lat);
        check("i_lat", lat, 5);
        i_read = 1'b0;
        check("i_rdata", i_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        check("i_addr", burst_addr, 32'h0000_1220);
        check("i_beats", tot_beats, 4);
        repeat (2) @(negedge clk);
        check("i_resp_once", i_resp_cnt, 1);
        check("i_resp_low", i_resp, 1'b0);

        // D writeback
        clear_counts();
        d_write = 1'b1; d_address = 32'h8000_0040;
        d_wdata = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                   64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        wait_resp(1'b1, 20, lat);
        check("wb_lat", lat, 5);
        d_write = 1'b0;
        check("wb_beat0", wlog[0], 64'hAAAA_AAAA_AAAA_AAAA);
        check("wb_beat1", wlog[1], 64'hBBBB_BBBB_BBBB_BBBB);
        check("wb_beat2", wlog[2], 64'hCCCC_CCCC_CCCC_CCCC);
        check("wb_beat3", wlog[3], 64'hDDDD_DDDD_DDDD_DDDD);
        check("wb_addr", burst_addr, 32'h8000_0040);
        check("wb_wr_cycles", wr_cyc, 4);
        repeat (2) @(negedge clk);
        check("wb_d_resp_once", d_resp_cnt, 1);
        check("wb_no_i_resp", i_resp_cnt, 0);

        // Simultaneous I and D reads
        set_tab(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                64'h0F0F_0F0F_F0F0_F0F0, 64'h5A5A_A5A5_5A5A_A5A5);
        clear_counts();
        i_read = 1'b1; i_address = 32'h0000_0100;
        d_read = 1'b1; d_address = 32'h0000_2000;
`ifdef CACHE_ARB_RR_EN
        wait_resp(1'b0, 20, lat);
        check("sim_first_i_lat", lat, 5);
        i_read = 1'b0;
        wait_resp(1'b1, 20, lat);
        check("sim_second_d_lat", lat, 6);
        d_read = 1'b0;
`else
        wait_resp(1'b1, 20, lat);
        check("sim_first_d_lat", lat, 5);
        d_read = 1'b0;
        wait_resp(1'b0, 20, lat);
        check("sim_second_i_lat", lat, 6);
        i_read = 1'b0;
`endif
        check("sim_i_rdata", i_rdata, tab_line());
        check("sim_d_rdata", d_rdata, tab_line());
        repeat (2) @(negedge clk);
        check("sim_resp_counts", {i_resp_cnt[7:0], d_resp_cnt[7:0]}, 16'h0101);

        // Wait-stated memory: resp only every 3rd strobe cycle
        set_tab(64'h1000_0000_0000_0001, 64'h2000_0000_0000_0002,
                64'h3000_0000_0000_0003, 64'h4000_0000_0000_0004);
        clear_counts();
        period = 3;
        d_read = 1'b1; d_address = 32'h3000_001F;
        wait_resp(1'b1, 40, lat);
        check("ws_lat", lat, 13);
        d_read = 1'b0;
        check("ws_d_rdata", d_rdata, tab_line());
        check("ws_addr", burst_addr, 32'h3000_0000);
        check("ws_addr_stable", stable_err, 0);
        check("ws_beats", tot_beats, 4);
        @(negedge clk);
        period = 1;

        // Reset during beat 2 of a D read, then a fresh burst
        set_tab(64'hAB00_0000_0000_00A0, 64'hAB00_0000_0000_00A1,
                64'hAB00_0000_0000_00A2, 64'hAB00_0000_0000_00A3);
        clear_counts();
        d_read = 1'b1; d_address = 32'h4000_0000;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_pmem_read", pmem_if.pmem_read, 1'b0);
        check("abort_d_rdata", d_rdata, 256'h0);
        check("abort_pmem_addr", pmem_if.pmem_address, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("abort_no_d_resp", d_resp_cnt, 0);
        tot_beats = 0;
        rst = 1'b0;
        wait_resp(1'b1, 20, lat);
        check("restart_lat", lat, 5);
        d_read = 1'b0;
        check("restart_beats", tot_beats, 4);
        check("restart_d_rdata", d_rdata, tab_line());
        repeat (2) @(negedge clk);
        check("restart_d_resp_once", d_resp_cnt, 1);

        // d_read and d_write together: write, then read to the same line
        set_tab(64'h7777_0000_0000_0001, 64'h7777_0000_0000_0002,
                64'h7777_0000_0000_0003, 64'h7777_0000_0000_0004);
        clear_counts();
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h5000_0080;
        d_wdata = {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
                   64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};
        wait_resp(1'b1, 20, lat);
        check("both_wr_lat", lat, 5);
        d_write = 1'b0;
        check("both_wr_beat0", wlog[0], 64'h1111_0000_0000_0001);
        check("both_wr_beat3", wlog[3], 64'h4444_0000_0000_0004);
        check("both_wr_cycles", wr_cyc, 4);
        wait_resp(1'b1, 20, lat);
        check("both_rd_lat", lat, 6);
        d_read = 1'b0;
        check("both_rd_addr", burst_addr, 32'h5000_0080);
        check("both_rd_rdata", d_rdata, tab_line());
        repeat (2) @(negedge clk);
        check("both_d_resp_two", d_resp_cnt, 2);
        check("both_wr_only_once", wr_cyc, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
